// File: rtl/rom_table_loader.sv
// rtl/rom_table_loader.sv - streams a table into ROM port A, then reads it back and checks it
//
// Purpose: accepts a start pulse, writes each transferred stream word to
// sequential ROM addresses from 0, waits out the ROM write path, reads every
// written word back and compares XOR checksums. Flags overflow or mismatch
// through a sticky error and blocks the lookup datapath until a clean load.
//
// Ports:
//   clock, reset        single clock, asynchronous active-high reset
//   start               one-cycle pulse that opens a load session (IDLE only)
//   s_data/s_valid/
//   s_last/s_ready      table word stream, transfer on s_valid && s_ready
//   rom_addr/rom_wr_data/
//   rom_wr_en/rom_q     ROM port A (read data valid 2 cycles after address)
//   lookup_hold         high while ROM contents must not be used
//   busy, done, error   status; done is a one-cycle pulse, error is sticky
//   word_count          words written in the current/last session
module rom_table_loader #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [AWIDTH-1:0] rom_addr,
  output logic [DWIDTH-1:0] rom_wr_data,
  output logic              rom_wr_en,
  input  logic [DWIDTH-1:0] rom_q,
  output logic              lookup_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [AWIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_VERIFY,
    S_FINISH
  } state_t;

  localparam logic [AWIDTH:0] DEPTH   = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [AWIDTH:0]   word_count_r;
  logic [DWIDTH-1:0] wr_sum, rd_sum, rd_sum_nx;
  logic              error_r, hold_r;
  logic              drain_cnt;
  logic [AWIDTH:0]   vcnt;           // cycles spent in VERIFY, doubles as read address
  logic [1:0]        vld;            // read-valid pipeline matching the ROM latency
  logic              xfer, overflow, rd_issue, verify_end;

  always_comb begin
    xfer       = (state == S_LOAD) && s_valid;
    overflow   = xfer && (word_count_r == DEPTH);
    rd_issue   = (state == S_VERIFY) && (vcnt < word_count_r);
    rd_sum_nx  = vld[1] ? (rd_sum ^ rom_q) : rd_sum;
    // Last read was issued at vcnt = word_count-1 and returns two cycles later.
    verify_end = (state == S_VERIFY) && (vcnt == word_count_r + CNT_ONE);
  end

  always_comb begin
    state_nx    = state;
    s_ready     = 1'b0;
    rom_wr_en   = 1'b0;
    rom_wr_data = '0;
    rom_addr    = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (overflow) begin
          state_nx = S_FINISH;
        end else if (xfer) begin
          rom_wr_en   = 1'b1;
          rom_wr_data = s_data;
          rom_addr    = word_count_r[AWIDTH-1:0];
          if (s_last) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt) state_nx = S_VERIFY;
      end
      S_VERIFY: begin
        if (rd_issue) rom_addr = vcnt[AWIDTH-1:0];
        if (verify_end) state_nx = S_FINISH;
      end
      S_FINISH: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      word_count_r <= '0;
      wr_sum       <= '0;
      rd_sum       <= '0;
      error_r      <= 1'b0;
      hold_r       <= 1'b1;
      drain_cnt    <= 1'b0;
      vcnt         <= '0;
      vld          <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            word_count_r <= '0;
            wr_sum       <= '0;
            rd_sum       <= '0;
            error_r      <= 1'b0;
            hold_r       <= 1'b1;
          end
        end
        S_LOAD: begin
          drain_cnt <= 1'b0;
          if (overflow) begin
            error_r <= 1'b1;
          end else if (xfer) begin
            word_count_r <= word_count_r + CNT_ONE;
            wr_sum       <= wr_sum ^ s_data;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          vcnt      <= '0;
          vld       <= '0;
        end
        S_VERIFY: begin
          vcnt   <= vcnt + CNT_ONE;
          vld    <= {vld[0], rd_issue};
          rd_sum <= rd_sum_nx;
          // Compare with the final read folded in so error is valid alongside done.
          if (verify_end && (rd_sum_nx != wr_sum)) error_r <= 1'b1;
        end
        S_FINISH: begin
          hold_r <= error_r;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FINISH);
  assign error       = error_r;
  assign lookup_hold = hold_r;
  assign word_count  = word_count_r;

endmodule

// File: tb/tb_rom_table_loader.sv
// tb/tb_rom_table_loader.sv - self-checking bench for rom_table_loader
module tb_rom_table_loader;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [3:0] rom_addr;
  logic [7:0] rom_wr_data;
  logic       rom_wr_en;
  logic [7:0] rom_q;
  logic       lookup_hold, busy, done, error;
  logic [4:0] word_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rom_table_loader #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .rom_addr(rom_addr), .rom_wr_data(rom_wr_data), .rom_wr_en(rom_wr_en),
    .rom_q(rom_q), .lookup_hold(lookup_hold), .busy(busy), .done(done),
    .error(error), .word_count(word_count)
  );

  // ROM model: registered write, 2-cycle read latency, optional corruption of address 2.
  logic [7:0] mem [0:15];
  logic [7:0] q1 = 8'h00;
  bit         corrupt = 1'b0;
  always @(posedge clock) begin
    if (rom_wr_en) mem[rom_addr] <= rom_wr_data;
    q1    <= (corrupt && rom_addr == 4'd2) ? 8'h45 : mem[rom_addr];
    rom_q <= q1;
  end

  // Monitor: only ever accumulates; sessions work on deltas.
  int wr_a[$];
  int wr_d[$];
  int done_cnt = 0, post_cyc = 0, stray_wr = 0, hold_at_done = 0, err_at_done = 0;
  always @(negedge clock) begin
    if (rom_wr_en) begin
      wr_a.push_back(int'(rom_addr));
      wr_d.push_back(int'(rom_wr_data));
      if (!(s_valid && s_ready)) stray_wr++;
    end
    if (busy && !s_ready) post_cyc++;
    if (done) begin
      done_cnt++;
      hold_at_done = int'(lookup_hold);
      err_at_done  = int'(error);
    end
  end

  logic [7:0] beats[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int pat, input int n);
    logic [7:0] b;
    beats.delete();
    for (int i = 0; i < n; i++) begin
      case (pat)
        0: begin b = 8'h11; b = b << (i % 4); end
        1: b = 8'h5A;
        2: b = 8'(i + 1);
        default: b = 8'($urandom);
      endcase
      beats.push_back(b);
    end
  endtask

  // Reference: what a session should produce, from the load rules alone.
  task automatic model(input int n, input bit has_last, input bit corr,
                       output int wc, output int err, output int post);
    int         accepted;
    bit         ovf;
    logic [7:0] ws, rs, v;
    accepted = has_last ? n : DEPTH + 1;
    ovf = (accepted > DEPTH);
    wc  = ovf ? DEPTH : accepted;
    ws = 8'h00;
    rs = 8'h00;
    for (int i = 0; i < wc; i++) begin
      ws ^= beats[i];
      v = (corr && i == 2) ? 8'h45 : beats[i];
      rs ^= v;
    end
    err  = (ovf || ws != rs) ? 1 : 0;
    post = ovf ? 1 : wc + 5;   // FINISH only, or DRAIN(2)+VERIFY(wc+2)+FINISH
  endtask

  task automatic run_session(input string nm, input int n, input bit has_last,
                             input int vmode, input bit corr, input bit poke,
                             input int exp_wc, input int exp_err, input int exp_post);
    int  base, d0, p0, s0, i, cyc, nw;
    bit  x;
    base = wr_a.size();
    d0 = done_cnt; p0 = post_cyc; s0 = stray_wr;
    corrupt = corr;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    i = 0; cyc = 0;
    while (i < n && cyc < 400) begin
      case (vmode)
        0: s_valid = 1'b1;
        1: s_valid = (cyc % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = beats[i];
      s_last = has_last && (i == n - 1);
      @(negedge clock); x = s_valid && s_ready;
      @(posedge clock); #1;
      if (x) i++;
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    chk({nm, " beats_sent"}, i, n);
    cyc = 0;
    while (done_cnt == d0 && cyc < 200) begin
      start = (poke && cyc == 3);
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, " done_seen"}, (done_cnt > d0) ? 1 : 0, 1);
    repeat (3) @(posedge clock);
    #1;
    nw = wr_a.size() - base;
    chk({nm, " n_writes"}, nw, exp_wc);
    for (int k = 0; k < nw && k < exp_wc; k++) begin
      chk($sformatf("%s wr_addr[%0d]", nm, k), wr_a[base + k], k);
      chk($sformatf("%s wr_data[%0d]", nm, k), wr_d[base + k], int'(beats[k]));
    end
    chk({nm, " stray_writes"}, stray_wr - s0, 0);
    chk({nm, " word_count"}, int'(word_count), exp_wc);
    chk({nm, " error"}, int'(error), exp_err);
    chk({nm, " error_at_done"}, err_at_done, exp_err);
    chk({nm, " done_pulses"}, done_cnt - d0, 1);
    chk({nm, " hold_at_done"}, hold_at_done, 1);
    chk({nm, " lookup_hold_after"}, int'(lookup_hold), exp_err);
    chk({nm, " post_load_cycles"}, post_cyc - p0, exp_post);
    chk({nm, " busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    string nm;
    int    pat;
    int    n;
    bit    has_last;
    int    vmode;
    bit    corr;
    bit    poke;
    int    exp_wc;
    int    exp_err;
    int    exp_post;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int wc, err, post, base, r, n, vm;
    bit hl, cr;

    vecs.push_back('{"basic4",      0, 4,  1'b1, 0, 1'b0, 1'b0, 4,  0, 9});
    vecs.push_back('{"toggle4",     0, 4,  1'b1, 1, 1'b0, 1'b0, 4,  0, 9});
    vecs.push_back('{"overflow17",  2, 17, 1'b0, 0, 1'b0, 1'b0, 16, 1, 1});
    vecs.push_back('{"corrupt2",    0, 4,  1'b1, 0, 1'b1, 1'b0, 4,  1, 9});
    vecs.push_back('{"start_in_vf", 0, 4,  1'b1, 0, 1'b0, 1'b1, 4,  0, 9});
    vecs.push_back('{"single5a",    1, 1,  1'b1, 0, 1'b0, 1'b0, 1,  0, 6});

    #12;
    chk("rst s_ready", int'(s_ready), 0);
    chk("rst rom_wr_en", int'(rom_wr_en), 0);
    chk("rst rom_addr", int'(rom_addr), 0);
    chk("rst rom_wr_data", int'(rom_wr_data), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst error", int'(error), 0);
    chk("rst word_count", int'(word_count), 0);
    chk("rst lookup_hold", int'(lookup_hold), 1);
    @(posedge clock); #1 reset = 1'b0;

    for (int v = 0; v < vecs.size(); v++) begin
      fill(vecs[v].pat, vecs[v].n);
      run_session(vecs[v].nm, vecs[v].n, vecs[v].has_last, vecs[v].vmode,
                  vecs[v].corr, vecs[v].poke, vecs[v].exp_wc, vecs[v].exp_err,
                  vecs[v].exp_post);
    end

    // Reset in the middle of LOAD, after two beats have been written.
    fill(0, 4);
    corrupt = 1'b0;
    base = wr_a.size();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    s_valid = 1'b1; s_data = beats[0];
    @(posedge clock); #1 s_data = beats[1];
    @(posedge clock); #1 s_data = beats[2];
    reset = 1'b1;
    #1;
    chk("midrst rom_wr_en", int'(rom_wr_en), 0);
    chk("midrst s_ready", int'(s_ready), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst error", int'(error), 0);
    chk("midrst word_count", int'(word_count), 0);
    chk("midrst rom_addr", int'(rom_addr), 0);
    chk("midrst lookup_hold", int'(lookup_hold), 1);
    @(posedge clock); #1;
    reset = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    chk("midrst writes_before", wr_a.size() - base, 2);
    repeat (2) @(posedge clock);
    #1;
    chk("midrst idle_no_write", wr_a.size() - base, 2);
    run_session("after_rst", 4, 1'b1, 0, 1'b0, 1'b0, 4, 0, 9);

    // Randomized sessions against the reference model.
    for (int t = 0; t < 8; t++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin n = DEPTH + 1; hl = 1'b0; end
      else begin n = $urandom_range(1, DEPTH); hl = 1'b1; end
      vm = $urandom_range(0, 2);
      cr = 1'($urandom_range(0, 1));
      fill(3, n);
      model(n, hl, cr, wc, err, post);
      run_session($sformatf("rand%0d", t), n, hl, vm, cr, 1'b0, wc, err, post);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
